// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: RV32 width codes,
// dmem transfer sizes, FSM state encoding and the request legality rule.
package dmem_lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    function automatic logic is_legal(input logic we, input logic [2:0] funct3);
        if (we) return funct3 inside {SB, SH, SW};
        return funct3 inside {LB, LH, LW, LBU, LHU};
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Pipeline request/response and dmem port bundle; the LSU sits on the slave
// modport, the pipeline/dmem side (or a bench) on the master modport.
interface dmem_lsu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [4:0]        req_rd;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic [4:0]        resp_rd;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_r_enable;
    logic              mem_w_enable;
    logic [1:0]        mem_w_size;
    logic [DATA_W-1:0] mem_w_data;
    logic [DATA_W-1:0] mem_r_data;
    logic              mem_ready;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        input  mem_r_data, mem_ready,
        output req_ready, resp_valid, resp_data, resp_rd, resp_err,
        output mem_addr, mem_r_enable, mem_w_enable, mem_w_size, mem_w_data
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        output mem_r_data, mem_ready,
        input  req_ready, resp_valid, resp_data, resp_rd, resp_err,
        input  mem_addr, mem_r_enable, mem_w_enable, mem_w_size, mem_w_data
    );
endinterface

// File: rtl/dmem_lsu_load_ext.sv
// Combinational load extension: selects byte/half/word from the low lanes of
// the returned dmem word and sign- or zero-extends it to 32 bits.
module load_ext
    import dmem_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] data
);

    always_comb begin
        // NOTE: default assignment first so every path drives data and no latch is inferred.
        data = raw;
        case (funct3)
            LB:      data = {{24{raw[7]}}, raw[7:0]};
            LBU:     data = {24'h0, raw[7:0]};
            LH:      data = {{16{raw[15]}}, raw[15:0]};
            LHU:     data = {16'h0, raw[15:0]};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: accepts one request at a time, runs a single dmem read or
// write, and returns a tagged, extended response (with illegal/timeout errors).
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic       clk,
    input  logic       reset,
    dmem_lsu_if.slave  bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              r_en_q;
    logic [DATA_W-1:0] ext_data;

    load_ext u_ext (
        .funct3 (funct3_q),
        .raw    (bus.mem_r_data),
        .data   (ext_data)
    );

    assign bus.mem_addr   = addr_q;
    assign bus.mem_w_data = wdata_q;
    // The read strobe falls in the ready cycle so a zero-wait dmem sees exactly one read.
    assign bus.mem_r_enable = r_en_q & ~bus.mem_ready;

    // NOTE: state and outputs are updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            cnt              <= '0;
            funct3_q         <= '0;
            addr_q           <= '0;
            wdata_q          <= '0;
            r_en_q           <= 1'b0;
            bus.mem_w_enable <= 1'b0;
            bus.mem_w_size   <= SZ_BYTE;
            bus.req_ready    <= 1'b1;
            bus.resp_valid   <= 1'b0;
            bus.resp_data    <= '0;
            bus.resp_rd      <= '0;
            bus.resp_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        funct3_q      <= bus.req_funct3;
                        bus.resp_rd   <= bus.req_rd;
                        bus.req_ready <= 1'b0;
                        if (!is_legal(bus.req_we, bus.req_funct3)) begin
                            state          <= RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                        end else if (bus.req_we) begin
                            state            <= WRITE;
                            addr_q           <= bus.req_addr;
                            wdata_q          <= bus.req_wdata;
                            bus.mem_w_size   <= bus.req_funct3[1:0];
                            bus.mem_w_enable <= 1'b1;
                        end else begin
                            state  <= READ;
                            addr_q <= bus.req_addr;
                            r_en_q <= 1'b1;
                            cnt    <= '0;
                        end
                    end
                end
                READ: begin
                    if (bus.mem_ready) begin
                        state          <= RESP;
                        r_en_q         <= 1'b0;
                        bus.resp_data  <= ext_data;
                        bus.resp_valid <= 1'b1;
                    end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        state          <= RESP;
                        r_en_q         <= 1'b0;
                        bus.resp_err   <= 1'b1;
                        bus.resp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WRITE: begin
                    state            <= RESP;
                    bus.mem_w_enable <= 1'b0;
                    bus.resp_valid   <= 1'b1;
                end
                RESP: begin
                    state          <= IDLE;
                    bus.resp_valid <= 1'b0;
                    bus.resp_err   <= 1'b0;
                    bus.resp_data  <= '0;
                    bus.req_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: loads, stores, illegal codes, read timeout,
// mid-transaction reset and back-to-back requests against hand-computed values.
module tb_dmem_lsu;
    import dmem_lsu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dmem_lsu_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_lsu #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic dmem_en = 1'b1;

    // dmem model: ready one cycle after r_enable is sampled
    always @(posedge clk or negedge reset) begin
        if (!reset) bus.mem_ready <= 1'b0;
        else        bus.mem_ready <= dmem_en && bus.mem_r_enable;
    end

    int r_cnt = 0, w_cnt = 0, resp_cnt = 0, both_cnt = 0;
    logic [31:0] raddr_seen = '0, waddr_seen = '0, wdata_seen = '0;
    logic [1:0]  wsize_seen = '0;

    always @(negedge clk) begin
        if (bus.mem_r_enable) begin
            r_cnt      <= r_cnt + 1;
            raddr_seen <= bus.mem_addr;
        end
        if (bus.mem_w_enable) begin
            w_cnt      <= w_cnt + 1;
            waddr_seen <= bus.mem_addr;
            wdata_seen <= bus.mem_w_data;
            wsize_seen <= bus.mem_w_size;
        end
        if (bus.mem_r_enable && bus.mem_w_enable) both_cnt <= both_cnt + 1;
        if (bus.resp_valid) resp_cnt <= resp_cnt + 1;
    end

    int          lat;
    logic [31:0] got_data;
    logic [4:0]  got_rd;
    logic        got_err;
    int          r0, w0;

    task automatic do_req(input string name, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
        @(negedge clk);
        r0 = r_cnt; w0 = w_cnt;
        checks++;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL %s req_ready before accept: got %b want 1", name, bus.req_ready); end
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
        bus.req_addr = addr; bus.req_wdata = wdata; bus.req_rd = rd;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) begin
                checks++;
                if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL %s req_ready busy: got %b want 0", name, bus.req_ready); end
            end
            if (bus.resp_valid === 1'b1) begin
                lat = n; got_data = bus.resp_data; got_rd = bus.resp_rd; got_err = bus.resp_err;
                break;
            end
        end
        #1;
        checks++;
        if (lat < 0) begin errors++; $display("FAIL %s no resp_valid within 40 cycles", name); end
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.req_rd = '0; bus.mem_r_data = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.mem_r_enable, bus.mem_w_enable, bus.resp_valid, bus.resp_err} !== 4'b0) begin
            errors++; $display("FAIL reset_enables: got %b want 0000", {bus.mem_r_enable, bus.mem_w_enable, bus.resp_valid, bus.resp_err});
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
        checks++;
        if ({bus.mem_addr, bus.mem_w_data, bus.resp_data} !== 96'h0) begin
            errors++; $display("FAIL reset_regs: addr %h wdata %h rdata %h want 0", bus.mem_addr, bus.mem_w_data, bus.resp_data);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3  [5] = '{LB, LBU, LHU, LH, LW};
        logic [31:0] adr [5] = '{32'h05, 32'h08, 32'h0A, 32'h0C, 32'h06};
        logic [31:0] raw [5] = '{32'h11223384, 32'h00008084, 32'h00008084, 32'h12348001, 32'hDEADBEEF};
        logic [31:0] exp [5] = '{32'hFFFFFF84, 32'h00000084, 32'h00008084, 32'hFFFF8001, 32'hDEADBEEF};
        for (int i = 0; i < 5; i++) begin
            bus.mem_r_data = raw[i];
            do_req("load", 1'b0, f3[i], adr[i], 32'h0, 5'(10 + i));
            checks++;
            if (lat !== 3) begin errors++; $display("FAIL load%0d latency: got %0d want 3", i, lat); end
            checks++;
            if (got_data !== exp[i]) begin errors++; $display("FAIL load%0d data: got %h want %h", i, got_data, exp[i]); end
            checks++;
            if (got_err !== 1'b0) begin errors++; $display("FAIL load%0d err: got %b want 0", i, got_err); end
            checks++;
            if (got_rd !== 5'(10 + i)) begin errors++; $display("FAIL load%0d rd: got %0d want %0d", i, got_rd, 10 + i); end
            checks++;
            if (r_cnt - r0 !== 1) begin errors++; $display("FAIL load%0d r_enable cycles: got %0d want 1", i, r_cnt - r0); end
            checks++;
            if (raddr_seen !== adr[i]) begin errors++; $display("FAIL load%0d mem_addr: got %h want %h", i, raddr_seen, adr[i]); end
            checks++;
            if (w_cnt != w0) begin errors++; $display("FAIL load%0d w_enable cycles: got %0d want 0", i, w_cnt - w0); end
        end
    endtask

    task automatic test_stores();
        logic [2:0]  f3  [3] = '{SB, SH, SW};
        logic [31:0] adr [3] = '{32'h3, 32'h22, 32'h10};
        logic [31:0] wd  [3] = '{32'hAABBCCDD, 32'h12345678, 32'h01020304};
        logic [1:0]  sz  [3] = '{2'b00, 2'b01, 2'b10};
        for (int i = 0; i < 3; i++) begin
            do_req("store", 1'b1, f3[i], adr[i], wd[i], 5'(20 + i));
            checks++;
            if (lat !== 2) begin errors++; $display("FAIL store%0d latency: got %0d want 2", i, lat); end
            checks++;
            if (w_cnt - w0 !== 1 || r_cnt != r0) begin
                errors++; $display("FAIL store%0d enable cycles: w %0d r %0d want 1 0", i, w_cnt - w0, r_cnt - r0);
            end
            checks++;
            if ({waddr_seen, wdata_seen, wsize_seen} !== {adr[i], wd[i], sz[i]}) begin
                errors++; $display("FAIL store%0d bus: addr %h data %h size %b want %h %h %b", i, waddr_seen, wdata_seen, wsize_seen, adr[i], wd[i], sz[i]);
            end
            checks++;
            if ({got_data, got_err, got_rd} !== {32'h0, 1'b0, 5'(20 + i)}) begin
                errors++; $display("FAIL store%0d resp: data %h err %b rd %0d want 0 0 %0d", i, got_data, got_err, got_rd, 20 + i);
            end
        end
    endtask

    task automatic test_illegal();
        logic       we [2] = '{1'b0, 1'b1};
        logic [2:0] f3 [2] = '{3'b011, 3'b100};
        for (int i = 0; i < 2; i++) begin
            do_req("illegal", we[i], f3[i], 32'h44, 32'hFFFF_FFFF, 5'(30 + i));
            checks++;
            if (lat !== 1) begin errors++; $display("FAIL illegal%0d latency: got %0d want 1", i, lat); end
            checks++;
            if (r_cnt != r0 || w_cnt != w0) begin errors++; $display("FAIL illegal%0d mem access: r %0d w %0d want 0 0", i, r_cnt - r0, w_cnt - w0); end
            checks++;
            if ({got_err, got_data, got_rd} !== {1'b1, 32'h0, 5'(30 + i)}) begin
                errors++; $display("FAIL illegal%0d resp: err %b data %h rd %0d want 1 0 %0d", i, got_err, got_data, got_rd, 30 + i);
            end
        end
    endtask

    task automatic test_timeout();
        dmem_en = 1'b0;
        bus.mem_r_data = 32'h5A5A5A5A;
        do_req("timeout", 1'b0, LW, 32'h20, 32'h0, 5'd9);
        checks++;
        if (r_cnt - r0 !== 15) begin errors++; $display("FAIL timeout r_enable cycles: got %0d want 15", r_cnt - r0); end
        checks++;
        if (lat !== 16) begin errors++; $display("FAIL timeout latency: got %0d want 16", lat); end
        checks++;
        if ({got_err, got_data, got_rd} !== {1'b1, 32'h0, 5'd9}) begin
            errors++; $display("FAIL timeout resp: err %b data %h rd %0d want 1 0 9", got_err, got_data, got_rd);
        end
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL timeout req_ready after: got %b want 1", bus.req_ready); end
        dmem_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        int p0;
        dmem_en = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = LW; bus.req_addr = 32'h30; bus.req_rd = 5'd4;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.mem_r_enable !== 1'b1) begin errors++; $display("FAIL midreset r_enable before: got %b want 1", bus.mem_r_enable); end
        #2 reset = 1'b0;
        #1;
        p0 = resp_cnt;
        checks++;
        if (bus.mem_r_enable !== 1'b0) begin errors++; $display("FAIL midreset r_enable async drop: got %b want 0", bus.mem_r_enable); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        dmem_en = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (resp_cnt != p0) begin errors++; $display("FAIL midreset resp_valid pulses: got %0d want 0", resp_cnt - p0); end
        bus.mem_r_data = 32'hCAFEF00D;
        do_req("after_reset", 1'b0, LW, 32'h34, 32'h0, 5'd5);
        checks++;
        if ({lat, got_data, got_err, got_rd} !== {32'd3, 32'hCAFEF00D, 1'b0, 5'd5}) begin
            errors++; $display("FAIL after_reset lw: lat %0d data %h err %b rd %0d want 3 cafef00d 0 5", lat, got_data, got_err, got_rd);
        end
    endtask

    task automatic test_back_to_back();
        int p0;
        @(negedge clk);
        w0 = w_cnt; p0 = resp_cnt;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = SB;
        bus.req_addr = 32'h40; bus.req_wdata = 32'h55; bus.req_rd = 5'd1;
        repeat (6) @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (w_cnt - w0 !== 2) begin errors++; $display("FAIL b2b accepted stores: got %0d want 2", w_cnt - w0); end
        checks++;
        if (resp_cnt - p0 !== 2) begin errors++; $display("FAIL b2b responses: got %0d want 2", resp_cnt - p0); end
        checks++;
        if (both_cnt !== 0) begin errors++; $display("FAIL r_enable and w_enable overlap: got %0d cycles want 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_illegal();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
